// File: rtl/uart_status_pkg.sv
// Shared types and helpers for the UART status monitor.
// Display mode encodings and width helpers.
package uart_status_pkg;

  typedef enum logic [1:0] {
    MODE_ACTIVITY = 2'd0,
    MODE_COUNT    = 2'd1,
    MODE_SUMMARY  = 2'd2,
    MODE_LAMP     = 2'd3
  } mode_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Holds a busy indicator high for STRETCH_CYCLES cycles
// after busy drops; any busy cycle reloads the hold time.
module pulse_stretcher #(
  parameter int STRETCH_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic arst,
  input  logic busy,
  output logic active
);

  localparam int CW = $clog2(STRETCH_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else begin
      active <= busy || (cnt != '0);
      if (busy)
        cnt <= CW'(STRETCH_CYCLES);
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/uart_status_monitor.sv
// Per-channel UART activity/error monitor driving a
// registered LED display with four selectable modes.
module uart_status_monitor
  import uart_status_pkg::*;
#(
  parameter int NUM_CHANNELS     = 1,
  parameter int LED_WIDTH        = 16,
  parameter int STRETCH_CYCLES   = 10_000_000,
  parameter int HEARTBEAT_CYCLES = 50_000_000,
  parameter int ERR_COUNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [NUM_CHANNELS-1:0] rx_busy,
  input  logic [NUM_CHANNELS-1:0] tx_busy,
  input  logic [NUM_CHANNELS-1:0] rx_error,
  input  logic                    clear,
  input  logic [1:0]              mode,
  input  logic [sel_width(NUM_CHANNELS)-1:0] sel,
  output logic [LED_WIDTH-1:0]    led
);

  localparam int NC = NUM_CHANNELS;
  localparam int EW = ERR_COUNT_WIDTH;
  localparam int HW = cnt_width(HEARTBEAT_CYCLES);
  localparam logic [EW-1:0] ERR_MAX = '1;

  if (3 * NUM_CHANNELS > LED_WIDTH) begin : g_bad_nc
    $error("3*NUM_CHANNELS exceeds LED_WIDTH");
  end
  if (ERR_COUNT_WIDTH > LED_WIDTH) begin : g_bad_ew
    $error("ERR_COUNT_WIDTH exceeds LED_WIDTH");
  end
  if (STRETCH_CYCLES < 1) begin : g_bad_st
    $error("STRETCH_CYCLES must be >= 1");
  end
  if (HEARTBEAT_CYCLES < 1) begin : g_bad_hb
    $error("HEARTBEAT_CYCLES must be >= 1");
  end

  logic [NC-1:0]    rx_act;
  logic [NC-1:0]    tx_act;
  logic [NC-1:0]    prev_err;
  logic [NC-1:0]    sticky;
  logic [NC-1:0]    err_evt;
  logic [NC*EW-1:0] cnt_flat;
  logic [HW-1:0]    hb_cnt;
  logic             hb;
  logic [LED_WIDTH-1:0] led_next;
  logic [EW-1:0]    cnt_sel;

  assign err_evt = rx_error & ~prev_err;

  for (genvar c = 0; c < NC; c++) begin : g_ch
    logic [EW-1:0] cnt;

    pulse_stretcher #(
      .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_rx (
      .clk(clk),
      .arst(arst),
      .busy(rx_busy[c]),
      .active(rx_act[c])
    );

    pulse_stretcher #(
      .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_tx (
      .clk(clk),
      .arst(arst),
      .busy(tx_busy[c]),
      .active(tx_act[c])
    );

    // An event in the same cycle as clear restarts the count at one.
    always_ff @(posedge clk or posedge arst) begin
      if (arst)
        cnt <= '0;
      else if (err_evt[c])
        cnt <= clear ? EW'(1) :
               (cnt == ERR_MAX) ? ERR_MAX : cnt + EW'(1);
      else if (clear)
        cnt <= '0;
    end

    assign cnt_flat[c*EW +: EW] = cnt;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      prev_err <= '0;
      sticky   <= '0;
    end else begin
      prev_err <= rx_error;
      sticky   <= err_evt | (sticky & ~{NC{clear}});
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hb_cnt == HW'(HEARTBEAT_CYCLES - 1)) begin
      hb_cnt <= '0;
      hb     <= ~hb;
    end else begin
      hb_cnt <= hb_cnt + HW'(1);
    end
  end

  always_comb begin
    led_next = '0;
    cnt_sel  = '0;
    for (int c = 0; c < NC; c++) begin
      if (int'(sel) == c)
        cnt_sel = cnt_flat[c*EW +: EW];
    end
    unique case (mode_e'(mode))
      MODE_ACTIVITY: begin
        for (int c = 0; c < NC; c++) begin
          led_next[2*c]           = rx_act[c];
          led_next[2*c+1]         = tx_act[c];
          led_next[LED_WIDTH-1-c] = sticky[c];
        end
      end
      MODE_COUNT: led_next[EW-1:0] = cnt_sel;
      MODE_SUMMARY: begin
        led_next[0] = hb;
        led_next[1] = |sticky;
        led_next[2] = |{rx_act, tx_act};
      end
      MODE_LAMP: led_next = '1;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      led <= '0;
    else
      led <= led_next;
  end

endmodule

// File: tb/tb_uart_status_monitor.sv
// Directed bench for uart_status_monitor with a
// cycle model feeding an expected-LED scoreboard.
module tb_uart_status_monitor;

  localparam int S = 4;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        arst;
  logic [1:0]  rx_busy, tx_busy, rx_error;
  logic        clear;
  logic [1:0]  mode;
  logic        sel;
  logic [15:0] led;

  logic [2:0]  z3 = '0;
  logic [2:0]  e3;
  logic        clear3 = 1'b0;
  logic [1:0]  mode3;
  logic [1:0]  sel3;
  logic [15:0] led3;

  always #5 clk = ~clk;

  uart_status_monitor #(
    .NUM_CHANNELS(2), .LED_WIDTH(16), .STRETCH_CYCLES(S),
    .HEARTBEAT_CYCLES(H), .ERR_COUNT_WIDTH(4)
  ) dut (
    .clk(clk), .arst(arst), .rx_busy(rx_busy),
    .tx_busy(tx_busy), .rx_error(rx_error),
    .clear(clear), .mode(mode), .sel(sel), .led(led)
  );

  uart_status_monitor #(
    .NUM_CHANNELS(3), .LED_WIDTH(16), .STRETCH_CYCLES(S),
    .HEARTBEAT_CYCLES(H), .ERR_COUNT_WIDTH(4)
  ) dut3 (
    .clk(clk), .arst(arst), .rx_busy(z3),
    .tx_busy(z3), .rx_error(e3),
    .clear(clear3), .mode(mode3), .sel(sel3), .led(led3)
  );

  int          rx_lr[2], tx_lr[2];
  bit   [1:0]  m_rx, m_tx, m_prev, m_sticky;
  logic [3:0]  m_cnt[2];
  bit          m_hb;
  int          m_hbc;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] q[$];
  logic [15:0] q3[$];
  string       tag;

  task automatic compare(input string t, input logic [15:0] got,
                         input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: led=%h expected=%h", t, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      rx_lr[c] = S + 1;
      tx_lr[c] = S + 1;
      m_cnt[c] = '0;
    end
    m_rx = '0; m_tx = '0; m_prev = '0; m_sticky = '0;
    m_hb = 1'b0; m_hbc = 0;
  endtask

  function automatic logic [15:0] model_led();
    logic [15:0] v;
    v = '0;
    case (mode)
      2'd0: for (int c = 0; c < 2; c++) begin
        v[2*c]   = m_rx[c];
        v[2*c+1] = m_tx[c];
        v[15-c]  = m_sticky[c];
      end
      2'd1: v[3:0] = m_cnt[sel];
      2'd2: begin
        v[0] = m_hb;
        v[1] = |m_sticky;
        v[2] = |{m_rx, m_tx};
      end
      default: v = 16'hFFFF;
    endcase
    return v;
  endfunction

  task automatic model_update();
    bit ev;
    for (int c = 0; c < 2; c++) begin
      if (rx_busy[c]) rx_lr[c] = 0;
      else if (rx_lr[c] <= S) rx_lr[c]++;
      m_rx[c] = (rx_lr[c] <= S);
      if (tx_busy[c]) tx_lr[c] = 0;
      else if (tx_lr[c] <= S) tx_lr[c]++;
      m_tx[c] = (tx_lr[c] <= S);
      ev = rx_error[c] & ~m_prev[c];
      if (ev) begin
        m_sticky[c] = 1'b1;
        if (clear) m_cnt[c] = 4'd1;
        else if (m_cnt[c] != 4'hF) m_cnt[c] = m_cnt[c] + 4'd1;
      end else if (clear) begin
        m_sticky[c] = 1'b0;
        m_cnt[c] = 4'd0;
      end
    end
    m_prev = rx_error;
    if (m_hbc == H - 1) begin
      m_hbc = 0;
      m_hb = ~m_hb;
    end else begin
      m_hbc++;
    end
  endtask

  task automatic step();
    q.push_back(model_led());
    model_update();
    @(posedge clk);
    #1;
    compare(tag, led, q.pop_front());
  endtask

  task automatic check3(input logic [15:0] exp);
    q3.push_back(exp);
    compare({tag, "_ch3"}, led3, q3.pop_front());
  endtask

  initial begin
    arst = 1'b1;
    rx_busy = '0; tx_busy = '0; rx_error = '0;
    clear = 1'b0; mode = 2'd0; sel = 1'b0;
    e3 = '0; mode3 = 2'd0; sel3 = 2'd0;
    model_reset();
    tag = "reset";
    #2;
    q.push_back(16'h0000);
    compare(tag, led, q.pop_front());
    check3(16'h0000);
    @(posedge clk);
    #1;
    arst = 1'b0;

    tag = "idle";
    repeat (2) step();

    tag = "stretch_rx1";
    rx_busy[1] = 1'b1;
    repeat (3) step();
    rx_busy[1] = 1'b0;
    repeat (8) step();

    tag = "retrigger_tx0";
    tx_busy[0] = 1'b1; step();
    tx_busy[0] = 1'b0; repeat (2) step();
    tx_busy[0] = 1'b1; step();
    tx_busy[0] = 1'b0; repeat (7) step();

    tag = "err_saturate";
    mode = 2'd1; sel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rx_error[0] = 1'b1; step();
      rx_error[0] = 1'b0; step();
    end
    step();
    tag = "sticky0";
    mode = 2'd0; repeat (2) step();
    tag = "clear0";
    mode = 2'd1; step();
    clear = 1'b1; step();
    clear = 1'b0; repeat (2) step();

    tag = "held_err1";
    sel = 1'b1;
    rx_error[1] = 1'b1; repeat (10) step();
    rx_error[1] = 1'b0; step();
    tag = "clear_vs_event";
    rx_error[1] = 1'b1; clear = 1'b1; step();
    clear = 1'b0; repeat (2) step();
    rx_error[1] = 1'b0;
    mode = 2'd0; repeat (2) step();

    tag = "heartbeat";
    clear = 1'b1; step();
    clear = 1'b0;
    mode = 2'd2;
    for (int i = 0; i < 3; i++) begin
      e3[2] = 1'b1; step();
      e3[2] = 1'b0; step();
    end
    for (int i = 0; i < 2; i++) begin
      e3[0] = 1'b1; step();
      e3[0] = 1'b0; step();
    end
    repeat (10) step();

    tag = "sel_range";
    mode3 = 2'd1; sel3 = 2'd2; repeat (2) step();
    check3(16'h0003);
    sel3 = 2'd3; step();
    check3(16'h0000);
    sel3 = 2'd0; step();
    check3(16'h0002);
    sel3 = 2'd3; step();
    check3(16'h0000);

    tag = "lamp";
    mode = 2'd3; rx_busy[0] = 1'b1; repeat (2) step();
    rx_busy[0] = 1'b0; rx_error[1] = 1'b1; step();
    tag = "arst_async";
    arst = 1'b1;
    #1;
    q.push_back(16'h0000);
    compare(tag, led, q.pop_front());
    check3(16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    tag = "arst_hold";
    q.push_back(16'h0000);
    compare(tag, led, q.pop_front());
    rx_busy[0] = 1'b1;
    arst = 1'b0;

    tag = "resume";
    mode = 2'd0; repeat (3) step();
    rx_busy[0] = 1'b0; repeat (6) step();
    mode = 2'd1; sel = 1'b1; repeat (2) step();
    rx_error[1] = 1'b0; step();
    mode = 2'd2; repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
